// File: rtl/omp_pkg.sv
// omp_pkg: shared definitions for the OMP-DRI iteration scheduler.
//   - dictionary / index / iteration widths
//   - final status codes reported by the scheduler
//   - scheduler state encoding
package omp_pkg;

    localparam int N_COLS = 64;   // dictionary columns
    localparam int IDX_W  = 6;    // column index (lambda) width
    localparam int ITER_W = 5;    // iteration index width, K <= 31

    typedef enum logic [1:0] {
        ST_KDONE = 2'd0,          // ran all K iterations
        ST_CONV  = 2'd1,          // residual fell below threshold
        ST_DUP   = 2'd2,          // Block A re-selected a column already in support
        ST_WDOG  = 2'd3           // an invoked block never answered
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_A = 3'd1,
        S_WAIT_B = 3'd2,
        S_WAIT_C = 3'd3,
        S_FIN    = 3'd4
    } state_e;

endpackage

// File: rtl/omp_support_set.sv
// omp_support_set: N_COLS-bit bitmap of the columns selected so far.
//   clk, rst      clock / async active-high reset
//   i_clr         clear the whole bitmap (wins over i_set)
//   i_set         set bit i_set_idx
//   i_set_idx     index to set
//   i_hit_idx     index to look up
//   o_hit         combinational: bit i_hit_idx is already set
//   o_bits        full bitmap
import omp_pkg::*;

module omp_support_set (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_set,
    input  logic [IDX_W-1:0]  i_set_idx,
    input  logic [IDX_W-1:0]  i_hit_idx,
    output logic              o_hit,
    output logic [N_COLS-1:0] o_bits
);

    logic [N_COLS-1:0] r_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bits <= '0;
        end else if (i_clr) begin
            r_bits <= '0;
        end else if (i_set) begin
            r_bits[i_set_idx] <= 1'b1;
        end
    end

    assign o_hit  = r_bits[i_hit_idx];
    assign o_bits = r_bits;

endmodule

// File: rtl/omp_iter_scheduler.sv
// omp_iter_scheduler: sequences Block A (argmax) -> Block B (MGS) -> Block C
// (residual update) for up to K iterations, tracking the support set and
// terminating on K reached, convergence, duplicate selection or watchdog.
//   clk, rst               clock / async active-high reset
//   start                  one-cycle request; k_limit, m_limit_in latched with it
//   done_a, lambda_a       Block A finished, argmax index valid
//   done_b, done_c         Block B / C finished
//   res_below              converged flag, sampled with done_c
//   start_a/_b/_c          one-cycle block start pulses
//   lambda, current_i      latched selected column / iteration index
//   M_limit                latched m_limit_in
//   support                bitmap of selected columns
//   busy, done, status     run in progress / completion pulse / final status
import omp_pkg::*;

module omp_iter_scheduler #(
    parameter int WD_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] k_limit,
    input  logic [2:0]        m_limit_in,
    input  logic              done_a,
    input  logic [IDX_W-1:0]  lambda_a,
    input  logic              done_b,
    input  logic              done_c,
    input  logic              res_below,
    output logic              start_a,
    output logic              start_b,
    output logic              start_c,
    output logic [IDX_W-1:0]  lambda,
    output logic [ITER_W-1:0] current_i,
    output logic [2:0]        M_limit,
    output logic [N_COLS-1:0] support,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status
);

    // Counter only ever needs to reach WD_CYCLES-1.
    localparam int WD_W = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_CYCLES - 1);

    state_e            r_state;
    state_e            w_nxt_state;
    status_e           r_status;
    status_e           w_nxt_status;
    logic [ITER_W-1:0] r_k;
    logic [2:0]        r_m;
    logic [IDX_W-1:0]  r_lambda;
    logic [ITER_W-1:0] r_cur_i;
    logic              r_start_a, r_start_b, r_start_c;
    logic [WD_W-1:0]   r_wd;

    logic w_start_a, w_start_b, w_start_c;
    logic w_accept;      // start accepted in IDLE
    logic w_set;         // record lambda_a into support / lambda
    logic w_inc;         // advance to next iteration
    logic w_hit;         // lambda_a already in support
    logic w_wd_to;       // watchdog expired this cycle
    logic w_waiting;
    logic w_last_iter;

    omp_support_set u_support (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_accept),
        .i_set     (w_set),
        .i_set_idx (lambda_a),
        .i_hit_idx (lambda_a),
        .o_hit     (w_hit),
        .o_bits    (support)
    );

    assign w_waiting   = (r_state == S_WAIT_A) || (r_state == S_WAIT_B) ||
                         (r_state == S_WAIT_C);
    assign w_wd_to     = (r_wd == WD_MAX);
    assign w_last_iter = (r_cur_i == ITER_W'(r_k - 1'b1));

    // Next-state / control. In every WAIT state the awaited done is checked
    // before the watchdog, so a done landing on the timeout cycle still wins.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_status = r_status;
        w_start_a    = 1'b0;
        w_start_b    = 1'b0;
        w_start_c    = 1'b0;
        w_accept     = 1'b0;
        w_set        = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_nxt_status = ST_KDONE;
                    if (k_limit == '0) begin
                        w_nxt_state = S_FIN;
                    end else begin
                        w_start_a   = 1'b1;
                        w_nxt_state = S_WAIT_A;
                    end
                end
            end
            S_WAIT_A: begin
                if (done_a) begin
                    if (w_hit) begin
                        w_nxt_status = ST_DUP;
                        w_nxt_state  = S_FIN;
                    end else begin
                        w_set       = 1'b1;
                        w_start_b   = 1'b1;
                        w_nxt_state = S_WAIT_B;
                    end
                end else if (w_wd_to) begin
                    w_nxt_status = ST_WDOG;
                    w_nxt_state  = S_FIN;
                end
            end
            S_WAIT_B: begin
                if (done_b) begin
                    w_start_c   = 1'b1;
                    w_nxt_state = S_WAIT_C;
                end else if (w_wd_to) begin
                    w_nxt_status = ST_WDOG;
                    w_nxt_state  = S_FIN;
                end
            end
            S_WAIT_C: begin
                if (done_c) begin
                    if (res_below) begin
                        w_nxt_status = ST_CONV;
                        w_nxt_state  = S_FIN;
                    end else if (w_last_iter) begin
                        w_nxt_status = ST_KDONE;
                        w_nxt_state  = S_FIN;
                    end else begin
                        w_inc       = 1'b1;
                        w_start_a   = 1'b1;
                        w_nxt_state = S_WAIT_A;
                    end
                end else if (w_wd_to) begin
                    w_nxt_status = ST_WDOG;
                    w_nxt_state  = S_FIN;
                end
            end
            S_FIN: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_status  <= ST_KDONE;
            r_start_a <= 1'b0;
            r_start_b <= 1'b0;
            r_start_c <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_status  <= w_nxt_status;
            r_start_a <= w_start_a;
            r_start_b <= w_start_b;
            r_start_c <= w_start_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k      <= '0;
            r_m      <= '0;
            r_cur_i  <= '0;
            r_lambda <= '0;
        end else begin
            if (w_accept) begin
                r_k     <= k_limit;
                r_m     <= m_limit_in;
                r_cur_i <= '0;
            end else if (w_inc) begin
                r_cur_i <= r_cur_i + 1'b1;
            end
            if (w_set) begin
                r_lambda <= lambda_a;
            end
        end
    end

    // Watchdog: restarts with every block start pulse, so each block
    // invocation gets a full WD_CYCLES budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (w_start_a || w_start_b || w_start_c) begin
            r_wd <= '0;
        end else if (w_waiting) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    assign start_a   = r_start_a;
    assign start_b   = r_start_b;
    assign start_c   = r_start_c;
    assign lambda    = r_lambda;
    assign current_i = r_cur_i;
    assign M_limit   = r_m;
    assign busy      = w_waiting;
    assign done      = (r_state == S_FIN);
    assign status    = r_status;

endmodule

// File: tb/tb_omp_iter_scheduler.sv
// tb_omp_iter_scheduler: directed test of omp_iter_scheduler with a short
// watchdog (WD_CYCLES=16). Outputs are sampled 1 time unit after each rising
// edge; inputs are driven at the same point.
import omp_pkg::*;

module tb_omp_iter_scheduler;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ITER_W-1:0] k_limit = '0;
    logic [2:0]        m_limit_in = '0;
    logic              done_a = 1'b0;
    logic [IDX_W-1:0]  lambda_a = '0;
    logic              done_b = 1'b0;
    logic              done_c = 1'b0;
    logic              res_below = 1'b0;
    logic              start_a, start_b, start_c;
    logic [IDX_W-1:0]  lambda;
    logic [ITER_W-1:0] current_i;
    logic [2:0]        M_limit;
    logic [N_COLS-1:0] support;
    logic              busy, done;
    logic [1:0]        status;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_sa = 0;
    int cnt_sb = 0;

    omp_iter_scheduler #(.WD_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_limit    (k_limit),
        .m_limit_in (m_limit_in),
        .done_a     (done_a),
        .lambda_a   (lambda_a),
        .done_b     (done_b),
        .done_c     (done_c),
        .res_below  (res_below),
        .start_a    (start_a),
        .start_b    (start_b),
        .start_c    (start_c),
        .lambda     (lambda),
        .current_i  (current_i),
        .M_limit    (M_limit),
        .support    (support),
        .busy       (busy),
        .done       (done),
        .status     (status)
    );

    always #5 clk = ~clk;

    // Pulse counters for start_a / start_b.
    always @(posedge clk) begin
        if (start_a) cnt_sa <= cnt_sa + 1;
        if (start_b) cnt_sb <= cnt_sb + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ITER_W-1:0] k, input logic [2:0] m);
        start = 1'b1;
        k_limit = k;
        m_limit_in = m;
        tick();
        start = 1'b0;
    endtask

    // Block model: raise done of block `which` (0=A,1=B,2=C) dly cycles
    // after the current cycle's start pulse.
    task automatic blk(input int which, input int dly, input logic [IDX_W-1:0] lam,
                       input logic rb);
        repeat (dly - 1) tick();
        case (which)
            0: begin done_a = 1'b1; lambda_a = lam; end
            1: done_b = 1'b1;
            default: begin done_c = 1'b1; res_below = rb; end
        endcase
        tick();
        done_a = 1'b0;
        done_b = 1'b0;
        done_c = 1'b0;
        res_below = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [IDX_W-1:0]  lams [3];
        logic [N_COLS-1:0] exp_sup;
        int sb0, sa0;
        lams[0] = 6'd39; lams[1] = 6'd4; lams[2] = 6'd27;

        // ---------------- reset state
        repeat (2) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_start_a", start_a, 1'b0);
        chk("rst_support", support, 64'd0);
        rst = 1'b0;
        tick();

        // ---------------- K=3, M=7, lambdas 39/4/27, runs to K
        do_start(5'd3, 3'd7);
        chk("t1_start_a", start_a, 1'b1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_mlimit", M_limit, 3'd7);
        for (int it = 0; it < 3; it++) begin
            blk(0, 10, lams[it], 1'b0);
            chk($sformatf("t1_start_b%0d", it), start_b, 1'b1);
            chk($sformatf("t1_lambda%0d", it), lambda, lams[it]);
            chk($sformatf("t1_cur_i%0d", it), current_i, it);
            blk(1, 10, '0, 1'b0);
            chk($sformatf("t1_start_c%0d", it), start_c, 1'b1);
            blk(2, 10, '0, 1'b0);
            if (it < 2) begin
                chk($sformatf("t1_next_a%0d", it), start_a, 1'b1);
                chk($sformatf("t1_next_i%0d", it), current_i, it + 1);
            end
        end
        chk("t1_done", done, 1'b1);
        chk("t1_status", status, 2'd0);
        chk("t1_busy_fin", busy, 1'b0);
        exp_sup = '0;
        exp_sup[39] = 1'b1; exp_sup[4] = 1'b1; exp_sup[27] = 1'b1;
        chk("t1_support", support, exp_sup);
        tick();
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_lambda_hold", lambda, 6'd27);

        // ---------------- K=5, converges on second done_c
        sb0 = cnt_sb;
        do_start(5'd5, 3'd2);
        chk("t2_support_clr", support, 64'd0);
        blk(0, 3, 6'd1, 1'b0);
        blk(1, 3, '0, 1'b0);
        blk(2, 3, '0, 1'b0);
        blk(0, 3, 6'd2, 1'b0);
        blk(1, 3, '0, 1'b0);
        blk(2, 3, '0, 1'b1);
        chk("t2_done", done, 1'b1);
        chk("t2_status", status, 2'd1);
        chk("t2_cur_i", current_i, 5'd1);
        chk("t2_nstart_b", cnt_sb - sb0, 2);
        tick();

        // ---------------- K=4, duplicate 12
        sb0 = cnt_sb;
        do_start(5'd4, 3'd1);
        blk(0, 2, 6'd12, 1'b0);
        blk(1, 2, '0, 1'b0);
        blk(2, 2, '0, 1'b0);
        blk(0, 2, 6'd12, 1'b0);
        chk("t3_done", done, 1'b1);
        chk("t3_status", status, 2'd2);
        chk("t3_start_b", start_b, 1'b0);
        chk("t3_lambda", lambda, 6'd12);
        tick();
        chk("t3_nstart_b", cnt_sb - sb0, 1);

        // ---------------- k_limit=0
        sa0 = cnt_sa;
        do_start(5'd0, 3'd4);
        chk("t4_done", done, 1'b1);
        chk("t4_status", status, 2'd0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_start_a", start_a, 1'b0);
        tick();
        chk("t4_nstart_a", cnt_sa - sa0, 0);

        // ---------------- start while busy is ignored (K=2)
        do_start(5'd2, 3'd1);
        blk(0, 3, 6'd7, 1'b0);
        sa0 = cnt_sa;
        start = 1'b1; k_limit = 5'd9;
        tick();
        start = 1'b0;
        chk("t5_busy", busy, 1'b1);
        chk("t5_start_a", start_a, 1'b0);
        chk("t5_cur_i", current_i, 5'd0);
        blk(1, 3, '0, 1'b0);
        chk("t5_nstart_a", cnt_sa - sa0, 0);
        blk(2, 3, '0, 1'b0);
        chk("t5_next_a", start_a, 1'b1);
        chk("t5_next_i", current_i, 5'd1);
        blk(0, 3, 6'd8, 1'b0);
        blk(1, 3, '0, 1'b0);
        blk(2, 3, '0, 1'b0);
        chk("t5_done", done, 1'b1);
        chk("t5_status", status, 2'd0);
        exp_sup = '0;
        exp_sup[7] = 1'b1; exp_sup[8] = 1'b1;
        chk("t5_support", support, exp_sup);
        tick();

        // ---------------- watchdog: done_b never arrives
        do_start(5'd2, 3'd3);
        blk(0, 2, 6'd5, 1'b0);
        chk("t6_start_b", start_b, 1'b1);
        repeat (15) tick();
        chk("t6_not_yet", done, 1'b0);
        chk("t6_busy_wait", busy, 1'b1);
        tick();
        chk("t6_done", done, 1'b1);
        chk("t6_status", status, 2'd3);
        tick();
        done_b = 1'b1;
        tick();
        done_b = 1'b0;
        chk("t6_spur_start_c", start_c, 1'b0);
        chk("t6_spur_busy", busy, 1'b0);
        chk("t6_status_hold", status, 2'd3);

        // ---------------- reset in WAIT_B
        do_start(5'd3, 3'd5);
        blk(0, 2, 6'd9, 1'b0);
        chk("t7_in_wait_b", start_b, 1'b1);
        rst = 1'b1;
        #1;
        chk("t7_rst_busy", busy, 1'b0);
        chk("t7_rst_start_b", start_b, 1'b0);
        chk("t7_rst_lambda", lambda, 6'd0);
        chk("t7_rst_support", support, 64'd0);
        chk("t7_rst_mlimit", M_limit, 3'd0);
        chk("t7_rst_status", status, 2'd0);
        tick();
        rst = 1'b0;
        tick();
        done_b = 1'b1;
        tick();
        done_b = 1'b0;
        chk("t7_spur_start_c", start_c, 1'b0);
        chk("t7_spur_busy", busy, 1'b0);
        do_start(5'd1, 3'd2);
        chk("t7_k1_start_a", start_a, 1'b1);
        blk(0, 2, 6'd33, 1'b0);
        blk(1, 2, '0, 1'b0);
        blk(2, 2, '0, 1'b0);
        chk("t7_k1_done", done, 1'b1);
        chk("t7_k1_status", status, 2'd0);
        exp_sup = '0;
        exp_sup[33] = 1'b1;
        chk("t7_k1_support", support, exp_sup);
        chk("t7_k1_mlimit", M_limit, 3'd2);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/omp_iter_scheduler.md
# omp_iter_scheduler

Iteration sequencer for the OMP-DRI reconstruction core. It runs the per-iteration chain Block A (correlation/argmax), then Block B (MGS, producing Q[i] and U[0:i,i]), then Block C (residual update), for up to K iterations. It latches the selected column index `lambda` and drives `current_i` and `M_limit` to the blocks. It maintains the support set, detects duplicate selections, early convergence and hung blocks, and reports a final status.

## Interface
- N_COLS, 64, dictionary columns (lambda range 0..N_COLS-1)
- IDX_W, 6, lambda width
- ITER_W, 5, iteration index width (max K = 31)
- WD_CYCLES, 4096, watchdog limit per block invocation

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a reconstruction
- k_limit  in  ITER_W  sparsity K (iterations to run), latched on start
- m_limit_in  in  3  DRI row limit, latched on start
- done_a  in  1  Block A finished, lambda_a valid this cycle
- lambda_a  in  IDX_W  argmax index from Block A
- done_b  in  1  Block B finished
- done_c  in  1  Block C finished
- res_below  in  1  residual-below-threshold flag, sampled with done_c
- start_a / start_b / start_c  out  1 each  one-cycle start pulses
- lambda  out  IDX_W  latched selected index, stable from start_b to next start
- current_i  out  ITER_W  current iteration index
- M_limit  out  3  latched m_limit_in
- support  out  N_COLS  bitmap of selected columns
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- status  out  2  0=K reached, 1=converged, 2=duplicate lambda, 3=watchdog; held until next start

## Operation
- States: IDLE, WAIT_A, WAIT_B, WAIT_C, FIN.
- IDLE + start: latch k_limit and m_limit_in, clear support, current_i=0.
  - If k_limit==0: go to FIN with status 0 and issue no block starts.
  - Otherwise pulse start_a and go to WAIT_A.
- start while busy: ignored. done_x outside its matching WAIT state: ignored.
- WAIT_A + done_a:
  - If support[lambda_a] is set: go to FIN with status 2; no start_b.
  - Otherwise set lambda=lambda_a and support[lambda_a]=1, pulse start_b, go to WAIT_B.
- WAIT_B + done_b: pulse start_c, go to WAIT_C.
- WAIT_C + done_c, evaluated in this order:
  - res_below: go to FIN with status 1.
  - current_i==k_limit-1: go to FIN with status 0.
  - Otherwise current_i++, pulse start_a, go to WAIT_A.
- Watchdog:
  - The counter clears on every start_x pulse and increments each cycle in a WAIT state.
  - When it reaches WD_CYCLES-1 without the awaited done: go to FIN with status 3.
  - If done and timeout coincide, done wins.
- FIN: pulse done for one cycle, drop busy, return to IDLE. lambda, current_i and support keep their values.
- Reset (any time, including mid-run): state=IDLE; all outputs 0, including support, lambda, current_i, M_limit and status. Blocks in flight are not notified; their later done_x pulses are ignored.

## Timing
- start sampled at cycle T → start_a and busy high at T+1.
- done_a at T → start_b at T+1, with lambda already updated at T+1.
- done_b at T → start_c at T+1.
- done_c at T → start_a at T+1 (next iteration, current_i incremented at T+1) or done at T+1.
- Duplicate or timeout detected at T → done at T+1.
- k_limit==0: done at T+1 with busy never asserted.
- A new start is accepted in IDLE the cycle after done.
- Scheduler overhead: 3 cycles per iteration beyond the block latencies.

## Structure
- Shared package omp_pkg holds:
  - N_COLS, IDX_W, ITER_W
  - status codes ST_KDONE, ST_CONV, ST_DUP, ST_WDOG
  - the state enum
- Sub-module omp_support_set holds the N_COLS-bit bitmap, with clear, set(idx) and a combinational hit(idx) lookup.
- The watchdog counter is inline.

## Test plan
- K=3, M_limit=7; Block A models return 39, 4, 27; blocks done after 10 cycles each, res_below=0 → current_i steps 0,1,2; lambda is 39/4/27 at each start_b; support has bits 39, 4, 27 set; done with status 0.
- K=5; res_below=1 on the second done_c → done one cycle later, status 1, current_i=1, exactly two start_b pulses.
- K=4; lambdas 12, 12 → no second start_b, status 2, lambda stays 12.
- WD_CYCLES=16, done_b never arrives → done 16 cycles after start_b, status 3; a later spurious done_b is ignored.
- rst pulsed in WAIT_B → all outputs 0 immediately; a subsequent done_b is ignored; a fresh start with K=1 completes with status 0.
- k_limit=0 → done at T+1, no start_a; start during busy has no effect on current_i or the start pulses.
